// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit delay line with per-stage valid bits, stall, flush
// and a registered occupancy count that tracks the number of valid stages.
module dff_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       d_valid,
  input  logic [WIDTH-1:0]           d,
  output logic                       q_valid,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Next state: flush clears valids only, data regs keep their contents.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      data_d[0]  = d;
      valid_d[0] = d_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Entry and exit cancel; bounded because occ equals popcount(valid).
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign occ     = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: a DEPTH=4 instance for pipeline behaviour
// and a DEPTH=1 instance compared against a reference flop.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, flush, dv;
  logic [7:0] d;
  logic       q4v;
  logic [7:0] q4;
  logic [2:0] occ4;

  logic       d1v;
  logic [7:0] d1;
  logic       q1v;
  logic [7:0] q1;
  logic [0:0] occ1;
  logic       en1    = 1'b1;
  logic       flush1 = 1'b0;
  logic [7:0] ref_q;

  logic [7:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d_valid(dv), .d(d),
    .q_valid(q4v), .q(q4), .occ(occ4)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .flush(flush1), .d_valid(d1v), .d(d1),
    .q_valid(q1v), .q(q1), .occ(occ1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ref_q <= d1;

  always @(negedge clk) begin
    if (!rst) begin
      assert (int'(occ4) == $countones(u_dut4.valid_q))
        else $error("FAIL occ_invariant occ=%0d valid=%b", occ4, u_dut4.valid_q);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    #2;
    vectors++;
    if (q4 !== 8'h3C) begin miscompares++; $display("FAIL rst_q got=%h exp=3c", q4); end
    vectors++;
    if (q4v !== 1'b0) begin miscompares++; $display("FAIL rst_qv got=%b exp=0", q4v); end
    vectors++;
    if (occ4 !== 3'd0) begin miscompares++; $display("FAIL rst_occ got=%0d exp=0", occ4); end
    tick();
    tick();
    rst = 1'b0;
    en  = 1'b1;
    dv  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'hC0 + 8'(i);
      exp_q.push_back(d);
      tick();
      if (q4v === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL rst_fill_extra got=%h", q4); end
        else begin
          e = exp_q.pop_front();
          if (q4 !== e) begin miscompares++; $display("FAIL rst_fill_q got=%h exp=%h", q4, e); end
        end
      end
    end
    vectors++;
    if (occ4 !== 3'd4) begin miscompares++; $display("FAIL rst_full_occ got=%0d exp=4", occ4); end
    // Assert reset mid-cycle with the pipe full; outputs must clear before the next edge.
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (q4 !== 8'h3C || q4v !== 1'b0 || occ4 !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_async got q=%h qv=%b occ=%0d exp q=3c qv=0 occ=0", q4, q4v, occ4);
    end
    exp_q.delete();
    en = 1'b0;
    dv = 1'b0;
    tick();
    vectors++;
    if (q4v !== 1'b0 || occ4 !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_hold got qv=%b occ=%0d exp qv=0 occ=0", q4v, occ4);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [7:0] e;
    logic [2:0] occ_s[5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    en = 1'b1;
    dv = 1'b1;
    d  = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 5; k++) begin
      tick();
      dv = 1'b0;
      d  = 8'h11 + 8'(k);
      vectors++;
      if (occ4 !== occ_s[k]) begin miscompares++; $display("FAIL lat_occ edge=%0d got=%0d exp=%0d", k, occ4, occ_s[k]); end
      vectors++;
      if (q4v !== (k == 3)) begin miscompares++; $display("FAIL lat_qv edge=%0d got=%b exp=%b", k, q4v, (k == 3)); end
      if (q4v === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL lat_extra got=%h", q4); end
        else begin
          e = exp_q.pop_front();
          if (q4 !== e) begin miscompares++; $display("FAIL lat_q got=%h exp=%h", q4, e); end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] e;
    logic       en_s[10]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic       dv_s[10]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [7:0] d_s[10]   = '{8'h01, 8'h02, 8'hEE, 8'hEE, 8'hEE, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [2:0] occ_s[10] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    logic       qv_s[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    for (int k = 0; k < 10; k++) begin
      en = en_s[k];
      dv = dv_s[k];
      d  = d_s[k];
      if (en && dv) exp_q.push_back(d);
      tick();
      vectors++;
      if (occ4 !== occ_s[k]) begin miscompares++; $display("FAIL stall_occ edge=%0d got=%0d exp=%0d", k, occ4, occ_s[k]); end
      vectors++;
      if (q4v !== qv_s[k]) begin miscompares++; $display("FAIL stall_qv edge=%0d got=%b exp=%b", k, q4v, qv_s[k]); end
      if (q4v === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL stall_extra got=%h", q4); end
        else begin
          e = exp_q.pop_front();
          if (q4 !== e) begin miscompares++; $display("FAIL stall_q got=%h exp=%h", q4, e); end
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_full();
    logic [7:0] e;
    logic [2:0] exp_occ;
    for (int k = 0; k < 10; k++) begin
      dv = (k < 6);
      d  = (k < 6) ? 8'h40 + 8'(k) : 8'h00;
      if (dv) exp_q.push_back(d);
      exp_occ = (k < 6) ? ((k < 3) ? 3'(k + 1) : 3'd4) : 3'(9 - k);
      tick();
      vectors++;
      if (occ4 !== exp_occ) begin miscompares++; $display("FAIL full_occ edge=%0d got=%0d exp=%0d", k, occ4, exp_occ); end
      vectors++;
      if (q4v !== (k >= 3 && k <= 8)) begin
        miscompares++;
        $display("FAIL full_qv edge=%0d got=%b exp=%b", k, q4v, (k >= 3 && k <= 8));
      end
      if (q4v === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL full_extra got=%h", q4); end
        else begin
          e = exp_q.pop_front();
          if (q4 !== e) begin miscompares++; $display("FAIL full_q got=%h exp=%h", q4, e); end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL full_drain left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_flush();
    en = 1'b1;
    dv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 8'h50 + 8'(k);
      exp_q.push_back(d);
      tick();
      vectors++;
      if (occ4 !== 3'(k + 1) || q4v !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_fill edge=%0d got occ=%0d qv=%b exp occ=%0d qv=0", k, occ4, q4v, k + 1);
      end
    end
    flush = 1'b1;
    d     = 8'hFF;
    tick();
    vectors++;
    if (occ4 !== 3'd0 || q4v !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_edge got occ=%0d qv=%b exp occ=0 qv=0", occ4, q4v);
    end
    exp_q.delete();
    flush = 1'b0;
    dv    = 1'b0;
    d     = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (q4v !== 1'b0 || occ4 !== 3'd0 || q4 === 8'hFF) begin
        miscompares++;
        $display("FAIL flush_after edge=%0d got q=%h qv=%b occ=%0d exp qv=0 occ=0 q!=ff", k, q4, q4v, occ4);
      end
    end
  endtask

  task automatic test_dff_equiv();
    logic [7:0] pd;
    logic       pv;
    for (int k = 0; k < 24; k++) begin
      d1  = 8'($urandom);
      d1v = 1'($urandom);
      pd  = d1;
      pv  = d1v;
      tick();
      vectors++;
      if (q1 !== ref_q || q1 !== pd) begin
        miscompares++;
        $display("FAIL dff_q cyc=%0d got=%h exp=%h ref=%h", k, q1, pd, ref_q);
      end
      vectors++;
      if (q1v !== pv || occ1 !== pv) begin
        miscompares++;
        $display("FAIL dff_valid cyc=%0d got qv=%b occ=%0d exp=%b", k, q1v, occ1, pv);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    flush = 1'b0;
    dv    = 1'b0;
    d     = 8'h00;
    d1    = 8'h00;
    d1v   = 1'b0;
    test_reset();
    test_latency();
    test_stall();
    test_full();
    test_flush();
    test_dff_equiv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
